// File: rtl/four_bit_down_counter_pkg.sv
// Shared constants for the 4-bit down counter and its bit-slice stage.
package four_bit_down_counter_pkg;

   localparam int          CNT_W    = 4;
   localparam logic [3:0]  CNT_ONES = 4'hF;
   localparam logic [3:0]  CNT_ZERO = 4'h0;

   // True when a count value sits at terminal count.
   function automatic logic is_zero(input logic [CNT_W-1:0] value);
      return (value == CNT_ZERO);
   endfunction

endpackage

// File: rtl/four_bit_down_counter_down_tff.sv
// One bit of the down counter: a toggle flip-flop with synchronous reset and
// parallel load, plus the borrow ripple to the next more-significant bit.
module down_tff_stage (
   input  logic clock,
   input  logic reset,
   input  logic load,
   input  logic load_bit,
   input  logic borrow_in,
   output logic q,
   output logic borrow_out
);

   // A bit toggles on a decrement once every lower bit is already 0.
   always_ff @(posedge clock) begin
      if (reset)
         q <= 1'b0;
      else if (load)
         q <= load_bit;
      else if (borrow_in)
         q <= ~q;
   end

   // The borrow continues upward only through bits that are 0.
   always_comb begin
      borrow_out = borrow_in & ~q;
   end

endmodule

// File: rtl/four_bit_down_counter.sv
// Cascadable 4-bit down counter with a hidden reload register.
// At zero the count either reloads from the register or wraps to all-ones.
// output_borrow feeds count_enable of the next more-significant stage.
module four_bit_down_counter
   import four_bit_down_counter_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             count_enable,
   input  logic             load,
   input  logic [CNT_W-1:0] D,
   input  logic             auto_reload,
   output logic [CNT_W-1:0] A,
   output logic             output_borrow
);

   logic [CNT_W-1:0] reload_q;
   logic [CNT_W:0]   borrow_chain;
   logic             at_zero;
   logic             zero_dec;
   logic             stage_load;
   logic [CNT_W-1:0] stage_value;

   // Decrement ripple enters the LSB directly from count_enable.
   always_comb begin
      borrow_chain[0] = count_enable;
   end

   genvar gi;
   generate
      for (gi = 0; gi < CNT_W; gi++) begin : g_bit
         down_tff_stage u_stage (
            .clock      (clock),
            .reset      (reset),
            .load       (stage_load),
            .load_bit   (stage_value[gi]),
            .borrow_in  (borrow_chain[gi]),
            .q          (A[gi]),
            .borrow_out (borrow_chain[gi+1])
         );
      end
   endgenerate

   // Reload register tracks the most recent parallel-load value.
   always_ff @(posedge clock) begin
      if (reset)
         reload_q <= CNT_ZERO;
      else if (load)
         reload_q <= D;
   end

   // Zero-crossing handling: a decrement at zero is turned into a load of
   // either the reload value or all-ones, so auto_reload matters only then.
   always_comb begin
      at_zero     = is_zero(A);
      zero_dec    = count_enable & at_zero & ~load;
      stage_load  = load | zero_dec;
      if (load)
         stage_value = D;
      else if (auto_reload)
         stage_value = reload_q;
      else
         stage_value = CNT_ONES;
   end

   // Terminal-count borrow, suppressed while loading or in reset.
   always_comb begin
      output_borrow = borrow_chain[CNT_W] & ~load & ~reset;
   end

endmodule

// File: tb/tb_four_bit_down_counter.sv
module tb_four_bit_down_counter;

   logic       clock = 1'b0;
   logic       reset;
   logic       count_enable;
   logic       load;
   logic [3:0] d_lo;
   logic       auto_reload;
   logic [3:0] a_lo;
   logic       borrow_lo;
   logic       hi_load;
   logic [3:0] d_hi;
   logic       hi_auto_reload;
   logic [3:0] a_hi;
   logic       borrow_hi;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clock = ~clock;

   four_bit_down_counter u_lo (
      .clock         (clock),
      .reset         (reset),
      .count_enable  (count_enable),
      .load          (load),
      .D             (d_lo),
      .auto_reload   (auto_reload),
      .A             (a_lo),
      .output_borrow (borrow_lo)
   );

   four_bit_down_counter u_hi (
      .clock         (clock),
      .reset         (reset),
      .count_enable  (borrow_lo),
      .load          (hi_load),
      .D             (d_hi),
      .auto_reload   (hi_auto_reload),
      .A             (a_hi),
      .output_borrow (borrow_hi)
   );

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // advance one clock edge; inputs change 1 time unit after it
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      int exp;
      reset = 1'b1; count_enable = 1'b1; load = 1'b1; d_lo = 4'h6; auto_reload = 1'b0;
      hi_load = 1'b0; d_hi = 4'h0; hi_auto_reload = 1'b0;
      #1;
      check_val("borrow_in_reset", {7'd0, borrow_lo}, 8'h00);
      step();
      check_val("reset_a", {4'h0, a_lo}, 8'h00);
      check_val("reset_a_hi", {4'h0, a_hi}, 8'h00);
      check_val("reset_borrow", {7'd0, borrow_lo}, 8'h00);

      // free-running wrap: 0, F, E, ..., 1, 0, F
      reset = 1'b0; load = 1'b0; count_enable = 1'b1; auto_reload = 1'b0;
      #1;
      for (int i = 0; i < 18; i++) begin
         exp = (32 - i) % 16;
         check_val("wrap_a", {4'h0, a_lo}, exp[7:0]);
         check_val("wrap_borrow", {7'd0, borrow_lo}, {7'd0, exp == 0});
         step();
      end

      // load 5 then auto-reload: 5,4,3,2,1,0,5,...
      load = 1'b1; d_lo = 4'h5; count_enable = 1'b0;
      step();
      load = 1'b0; count_enable = 1'b1; auto_reload = 1'b1;
      #1;
      for (int i = 0; i < 14; i++) begin
         exp = 5 - (i % 6);
         check_val("reload_a", {4'h0, a_lo}, exp[7:0]);
         check_val("reload_borrow", {7'd0, borrow_lo}, {7'd0, exp == 0});
         step();
      end

      // load beats decrement at zero
      load = 1'b1; d_lo = 4'h0; count_enable = 1'b0;
      step();
      check_val("load_zero", {4'h0, a_lo}, 8'h00);
      load = 1'b1; d_lo = 4'h9; count_enable = 1'b1;
      #1;
      check_val("load_wins_borrow", {7'd0, borrow_lo}, 8'h00);
      step();
      check_val("load_wins_a", {4'h0, a_lo}, 8'h09);
      load = 1'b0; count_enable = 1'b0; auto_reload = 1'b1;
      step();
      step();
      check_val("hold_a", {4'h0, a_lo}, 8'h09);
      check_val("hold_borrow", {7'd0, borrow_lo}, 8'h00);

      // auto_reload toggling away from zero is ignored; at zero 0 -> wrap to F
      count_enable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         auto_reload = (i == 9) ? 1'b0 : i[0];
         #1;
         exp = 9 - i;
         check_val("ar_ignore_a", {4'h0, a_lo}, exp[7:0]);
         step();
      end
      check_val("ar_zero_wrap", {4'h0, a_lo}, 8'h0F);

      // reset mid-count overrides load and clears R
      load = 1'b1; d_lo = 4'h9; count_enable = 1'b0;
      step();
      load = 1'b0; count_enable = 1'b1;
      step();
      step();
      check_val("reach_7", {4'h0, a_lo}, 8'h07);
      reset = 1'b1; load = 1'b1; d_lo = 4'hC;
      #1;
      check_val("rst_borrow", {7'd0, borrow_lo}, 8'h00);
      step();
      check_val("rst_over_load", {4'h0, a_lo}, 8'h00);
      reset = 1'b0; load = 1'b0; auto_reload = 1'b1; count_enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_val("post_rst_a", {4'h0, a_lo}, 8'h00);
         check_val("post_rst_borrow", {7'd0, borrow_lo}, 8'h01);
         step();
      end

      // divide-by-1: R=0, borrow mirrors count_enable
      load = 1'b1; d_lo = 4'h0; count_enable = 1'b0;
      step();
      load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         count_enable = (i != 1);
         #1;
         check_val("div1_a", {4'h0, a_lo}, 8'h00);
         check_val("div1_borrow", {7'd0, borrow_lo}, {7'd0, count_enable});
         step();
      end

      // two chained stages: 00, FF, FE, ..., 00
      load = 1'b1; d_lo = 4'h0; hi_load = 1'b1; d_hi = 4'h0;
      auto_reload = 1'b0; hi_auto_reload = 1'b0; count_enable = 1'b1;
      step();
      load = 1'b0; hi_load = 1'b0;
      #1;
      for (int i = 0; i <= 256; i++) begin
         exp = (256 - i) % 256;
         check_val("chain_val", {a_hi, a_lo}, exp[7:0]);
         check_val("chain_borrow_lo", {7'd0, borrow_lo}, {7'd0, (exp % 16) == 0});
         check_val("chain_borrow_hi", {7'd0, borrow_hi}, {7'd0, exp == 0});
         step();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/four_bit_down_counter.md
FOUR_BIT_DOWN_COUNTER -- requirements
Module: four_bit_down_counter

Interface
REQ-001 The block SHALL have no parameters; the count width is fixed at 4 bits.
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 count_enable  input  1  decrement request for this cycle; chains from the output_borrow of a lower stage.
REQ-005 load  input  1  parallel-load strobe.
REQ-006 D  input  4  parallel-load value.
REQ-007 auto_reload  input  1  selects the next state after zero: 1 = reload from R, 0 = wrap to 4'hF.
REQ-008 A  output  4  current count (registered).
REQ-009 output_borrow  output  1  combinational terminal-count or borrow indication for cascading.

Function
REQ-010 The block SHALL hold an internal 4-bit reload register R that is not visible at any port.
REQ-011 Per-edge update priority SHALL be: reset, then load, then count_enable, then hold.
REQ-012 load=1: A SHALL take D and R SHALL take D on the same edge; count_enable SHALL be ignored in that cycle.
REQ-013 count_enable=1, load=0, A!=0: A SHALL take A-1 and R SHALL be unchanged.
REQ-014 count_enable=1, load=0, A==0, auto_reload=1: A SHALL take R.
REQ-015 count_enable=1, load=0, A==0, auto_reload=0: A SHALL take 4'hF (modulo-16 wrap).
REQ-016 count_enable=0, load=0: A and R SHALL hold.
REQ-017 output_borrow SHALL be count_enable AND (A==0) AND NOT load AND NOT reset, with zero-cycle latency.
REQ-018 When auto_reload=1 and R==0, A SHALL remain 0 and output_borrow SHALL equal count_enable every cycle (divide-by-1).
REQ-019 The reload period with auto_reload=1 SHALL be R+1 enabled cycles between output_borrow pulses.
REQ-020 Stages chained by feeding output_borrow of stage N to count_enable of stage N+1 SHALL form a correct multi-digit binary down counter when auto_reload=0.
REQ-021 auto_reload SHALL be sampled only in the cycle in which A==0 and a decrement occurs; changing it at any other time SHALL have no effect on the count.
REQ-022 There SHALL be no illegal states; all 16 values of A SHALL be reachable and well-defined.

Reset
REQ-023 reset=1 SHALL set A to 4'h0 and R to 4'h0 on the next rising edge, overriding load and count_enable.
REQ-024 output_borrow SHALL be 0 in every cycle in which reset=1.
REQ-025 Reset asserted mid-count SHALL discard the count and R with no residual state; counting SHALL resume from 0 in the first cycle after reset is released.

Structure
REQ-026 A shared package SHALL define the count width constant (4), the all-ones value (4'hF) and the zero value (4'h0).
REQ-027 Each bit SHALL be built from a sub-module down_tff_stage containing:
 - a toggle flip-flop with synchronous reset and load;
 - a toggle enable equal to count_enable AND all lower bits of A equal to 0;
 - its own borrow-out to the next bit.
 This mirrors the existing carry-chain counter in the down direction.
REQ-028 The reload multiplexing at zero SHALL sit in the top level, outside down_tff_stage.

Verification
REQ-029 Reset, then count_enable=1 held for 17 cycles with auto_reload=0 -> A sequence 0, F, E, ..., 1, 0, F; output_borrow high only in the cycles where A=0.
REQ-030 load=1 with D=4'h5, then count_enable=1 and auto_reload=1 -> A sequence 5, 4, 3, 2, 1, 0, 5, 4, ...; output_borrow pulses every 6 enabled cycles.
REQ-031 A=0 with load=1, D=4'h9 and count_enable=1 in the same cycle -> output_borrow=0 in that cycle; A=9 next cycle (load wins).
REQ-032 Two stages chained (low borrow to high count_enable), both loaded with 0, count_enable=1 -> concatenated value FF, FE, ..., 00 over 256 cycles; high stage decrements only when the low stage passes 0 to F.
REQ-033 Count reaches 4'h7, then reset=1 together with load=1, D=4'hC -> A=0 next cycle, output_borrow=0 during reset; with auto_reload=1 and count_enable=1 after reset, A stays 0 (R cleared).
REQ-034 auto_reload=1, load D=0, count_enable toggled 1, 0, 1 -> A stays 0; output_borrow follows count_enable exactly.
